// File: rtl/cordic_sequencer_if.sv
// Start/busy/done handshake and operand/result bus between the register
// interface (master) and the CORDIC sequencer (slave).
interface cordic_sequencer_if #(
  parameter int unsigned FIXED_WIDTH = 16
);
  logic                          start;
  logic [1:0]                    mode;
  logic                          vectoring;
  logic signed [FIXED_WIDTH-1:0] x_in;
  logic signed [FIXED_WIDTH-1:0] y_in;
  logic signed [FIXED_WIDTH-1:0] z_in;
  logic                          busy;
  logic                          done;
  logic                          error;
  logic signed [FIXED_WIDTH-1:0] x_out;
  logic signed [FIXED_WIDTH-1:0] y_out;
  logic signed [FIXED_WIDTH-1:0] z_out;

  modport master (
    output start, mode, vectoring, x_in, y_in, z_in,
    input  busy, done, error, x_out, y_out, z_out
  );

  modport slave (
    input  start, mode, vectoring, x_in, y_in, z_in,
    output busy, done, error, x_out, y_out, z_out
  );
endinterface

// File: rtl/cordic_sequencer.sv
// Iterative CORDIC controller: one micro-rotation per cycle for ITERATIONS cycles,
// circular and linear modes, rotation and vectoring.
module cordic_sequencer #(
  parameter int unsigned FIXED_WIDTH = 16,
  parameter int unsigned ITERATIONS  = 9
) (
  input logic               clk,
  input logic               rst,
  cordic_sequencer_if.slave bus
);
  localparam int unsigned CntW  = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
  localparam int unsigned FracW = FIXED_WIDTH - 2;

  typedef logic signed [FIXED_WIDTH-1:0] word_t;
  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            lin_q, vec_q, error_q;
  word_t           x_q, y_q, z_q;
  word_t           x_out_q, y_out_q, z_out_q;

  logic  sigma_pos, last;
  word_t x_d, y_d, z_d, xs, ys, dz;

  // Circular angles are atan(2^-i) in Q2.14; past the table, atan(2^-i) ~= 2^-i.
  function automatic word_t delta_z(input logic lin, input logic [CntW-1:0] idx);
    logic [31:0] v;
    v = (32'd1 << FracW) >> idx;
    if (!lin) begin
      case (int'(idx))
        0: v = 32'd12868;
        1: v = 32'd7596;
        2: v = 32'd4014;
        3: v = 32'd2037;
        4: v = 32'd1023;
        5: v = 32'd512;
        6: v = 32'd256;
        7: v = 32'd128;
        8: v = 32'd64;
        default: ;
      endcase
    end
    return word_t'(v);
  endfunction

  always_comb begin
    sigma_pos = vec_q ? y_q[FIXED_WIDTH-1] : ~z_q[FIXED_WIDTH-1];
    dz        = delta_z(lin_q, cnt_q);
    xs        = x_q >>> cnt_q;
    ys        = y_q >>> cnt_q;
    if (sigma_pos) begin
      x_d = lin_q ? x_q : x_q - ys;
      y_d = y_q + xs;
      z_d = z_q - dz;
    end else begin
      x_d = lin_q ? x_q : x_q + ys;
      y_d = y_q - xs;
      z_d = z_q + dz;
    end
    last = (cnt_q == CntW'(ITERATIONS - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      lin_q   <= 1'b0;
      vec_q   <= 1'b0;
      error_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      x_out_q <= '0;
      y_out_q <= '0;
      z_out_q <= '0;
    end else begin
      case (state_q)
        StRun: begin
          x_q   <= x_d;
          y_q   <= y_d;
          z_q   <= z_d;
          cnt_q <= cnt_q + CntW'(1);
          if (last) begin
            x_out_q <= x_d;
            y_out_q <= y_d;
            z_out_q <= z_d;
            state_q <= StDone;
          end
        end
        default: begin
          // Idle and Done both accept, so operations can run back-to-back.
          if (bus.start) begin
            if (bus.mode[1]) begin
              error_q <= 1'b1;
              state_q <= StDone;
            end else begin
              x_q     <= bus.x_in;
              y_q     <= bus.y_in;
              z_q     <= bus.z_in;
              lin_q   <= bus.mode[0];
              vec_q   <= bus.vectoring;
              cnt_q   <= '0;
              error_q <= 1'b0;
              state_q <= StRun;
            end
          end else begin
            state_q <= StIdle;
          end
        end
      endcase
    end
  end

  assign bus.busy  = (state_q == StRun);
  assign bus.done  = (state_q == StDone);
  assign bus.error = error_q;
  assign bus.x_out = x_out_q;
  assign bus.y_out = y_out_q;
  assign bus.z_out = z_out_q;
endmodule

// File: doc/cordic_sequencer.md
Name: cordic_sequencer

Overview:
Iterative CORDIC controller that drives a single CORDIC_iteration datapath instance for ITERATIONS cycles per operation.
- Owns the x/y/z state registers, the iteration counter (shift), the per-iteration delta_z lookup and the sigma decision.
- Supports rotation and vectoring in circular and linear modes.
- Sits between the peripheral register interface and the datapath; exposes a start/busy/done handshake.

Parameters:
- FIXED_WIDTH, 16, two's-complement word width of x, y, z (Q2.14: 2 integer bits incl. sign, 14 fraction bits).
- ITERATIONS, 9, micro-iterations per operation; shift runs 0..ITERATIONS-1.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  request a new operation; sampled only when busy=0.
- mode  input  2  CIRCULAR 2'b00, LINEAR 2'b01, HYPERBOLIC 2'b10, 2'b11 reserved.
- vectoring  input  1  0 = rotation (drive z to 0), 1 = vectoring (drive y to 0).
- x_in, y_in, z_in  input  FIXED_WIDTH each  operands, Q2.14, latched on accepted start.
- busy  output  1  high while iterations are running.
- done  output  1  one-cycle pulse when results are valid.
- error  output  1  set when an unsupported mode is requested; cleared by the next accepted start.
- x_out, y_out, z_out  output  FIXED_WIDTH each  result registers, held until the next operation completes.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state=IDLE, counter=0, busy=0, done=0, error=0, x_out/y_out/z_out=0, internal x/y/z=0.
- FSM states: IDLE, RUN, DONE. busy = (state==RUN); done = (state==DONE).
- Start acceptance: start is accepted when state is IDLE or DONE, which allows back-to-back operations. start while RUN is ignored and not queued.
- Accepted start, mode CIRCULAR or LINEAR:
  - Latch x_in/y_in/z_in into x/y/z, latch mode and vectoring.
  - counter=0, error=0, go to RUN.
- Accepted start, mode HYPERBOLIC or 2'b11:
  - error=1, go to DONE directly. Outputs keep their previous values.
  - done pulses on the cycle after start.
- RUN, each cycle:
  - Datapath inputs: shift=counter, delta_z=LUT[mode][counter], is_sigma_positive per the rule below.
  - Register x/y/z <= next_x/next_y/next_z; counter++.
  - When counter==ITERATIONS-1, also load x_out/y_out/z_out from next_* and go to DONE.
- DONE: lasts exactly one cycle, then IDLE unless a new start is accepted that same cycle.
- Latency: start sampled at edge E0 -> ITERATIONS RUN cycles -> done high in the cycle after edge E(ITERATIONS). Default: done asserted 10 cycles after start.
- Sigma rule:
  - Rotation: sigma_positive = (z >= 0).
  - Vectoring: sigma_positive = (y < 0).
- delta_z LUT, Q2.14, indexed by counter 0..8:
  - Circular, atan(2^-i): 12868, 7596, 4014, 2037, 1023, 512, 256, 128, 64.
  - Linear, 2^-i: 16384 >> i.
  - Indices >= 9, when ITERATIONS > 9: circular uses 16384 >> i (small-angle approximation); linear is unchanged.
- Arithmetic: all datapath arithmetic wraps modulo 2^FIXED_WIDTH; no saturation.
- Gain: no gain compensation. For circular mode the caller pre-scales x_in by 1/K (K9 ≈ 1.6468).
- Convergence domain (caller responsibility):
  - Circular: |z| <= 1.74 rad.
  - Linear: |z| < 2 and |y/x| < 2.
- Input stability: inputs other than start are don't-care outside the accepting cycle.
- Reset mid-operation: returns to IDLE within the same edge; done is not pulsed, outputs are cleared.
- Simultaneous start and rst: rst wins.

Test Plan:
- Circular rotation: x_in=9949, y_in=0, z_in=12868 (pi/4) -> done exactly 10 cycles after start; x_out ≈ 11585, y_out ≈ 11585 (±64 LSB), |z_out| <= 64.
- Circular vectoring: x_in=8192, y_in=8192, z_in=0 -> z_out ≈ 12868 (±64), x_out ≈ 19079 (±96), |y_out| <= 64.
- Linear rotation: x_in=8192, y_in=0, z_in=8192 -> y_out ≈ 4096 (±32), x_out=8192 exactly. Linear vectoring: x_in=8192, y_in=4096, z_in=0 -> z_out ≈ 8192 (±64).
- Hyperbolic request: mode=2'b10 -> busy never high, done and error high one cycle after start, outputs unchanged. Next valid start clears error.
- Handshake:
  - start held high through an entire run -> exactly one operation per accepted start; re-acceptance in the DONE cycle gives back-to-back dones 10 cycles apart.
  - start pulsed during RUN -> ignored.
- Reset: assert rst at RUN cycle 4 -> next cycle busy=0, done=0, outputs=0; a following start completes normally.
